// File: rtl/mem_bus_if.sv
// Word-aligned data-memory bus between the load/store unit (master) and memory (slave).
// The request side is registered by the master; the response is sampled only while mem_req is high.
interface mem_bus_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns the EX/MEM access into a byte-enabled bus transaction,
// stalls the pipeline until ack or timeout, and returns the aligned, extended load data.
//
// state  | meaning
// S_IDLE | waiting for a load/store; a legal access latches the bus fields and raises mem_req
// S_BUSY | request outstanding; waits for mem_ack or times out after TIMEOUT cycles
// S_DONE | pipeline released for one cycle so the access retires; inputs ignored
module mem_access_unit #(
   parameter int TIMEOUT = 15,
   parameter int TO_W    = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load_m,
   input  logic        i_mem_write_m,
   input  logic [2:0]  i_funct3_m,
   input  logic [31:0] i_alu_result_m,
   input  logic [31:0] i_write_data_m,
   output logic [31:0] o_read_data_m,
   output logic        o_stall_m,
   output logic        o_misalign_m,
   output logic        o_bus_err_m,
   mem_bus_if.master   bus
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t            r_state;
   logic [TO_W-1:0]   r_cnt;
   logic [2:0]        r_funct3;
   logic [1:0]        r_lane;
   logic              r_bus_err;
   logic [31:0]       r_read_data;

   logic              w_op;
   logic              w_illegal;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_load_val;
   logic [TO_W-1:0]   w_cnt_next;

   assign w_op       = i_load_m | i_mem_write_m;
   assign w_cnt_next = r_cnt + 1'b1;

   always_comb begin
      case (i_funct3_m)
         3'b000, 3'b100: w_illegal = 1'b0;
         3'b001, 3'b101: w_illegal = i_alu_result_m[0];
         3'b010:         w_illegal = (i_alu_result_m[1:0] != 2'b00);
         default:        w_illegal = 1'b1;
      endcase
   end

   // Loads drive the same enables a store of that size would, so memory sees the touched lanes.
   always_comb begin
      case (i_funct3_m[1:0])
         2'b00: begin
            w_be    = 4'b0001 << i_alu_result_m[1:0];
            w_wdata = {4{i_write_data_m[7:0]}};
         end
         2'b01: begin
            w_be    = i_alu_result_m[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_write_data_m[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = i_write_data_m;
         end
      endcase
   end

   always_comb begin
      case (r_lane)
         2'd0:    w_byte = bus.mem_rdata[7:0];
         2'd1:    w_byte = bus.mem_rdata[15:8];
         2'd2:    w_byte = bus.mem_rdata[23:16];
         default: w_byte = bus.mem_rdata[31:24];
      endcase
      w_half = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (r_funct3)
         3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load_val = {24'd0, w_byte};
         3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
         3'b101:  w_load_val = {16'd0, w_half};
         default: w_load_val = bus.mem_rdata;
      endcase
   end

   assign o_stall_m     = (r_state == S_BUSY) ||
                          ((r_state == S_IDLE) && w_op && !w_illegal);
   assign o_misalign_m  = (r_state == S_IDLE) && w_op && w_illegal;
   assign o_bus_err_m   = r_bus_err;
   assign o_read_data_m = r_read_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_funct3      <= 3'd0;
         r_lane        <= 2'd0;
         r_bus_err     <= 1'b0;
         r_read_data   <= 32'd0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= 32'd0;
         bus.mem_be    <= 4'd0;
         bus.mem_wdata <= 32'd0;
      end else begin
         r_bus_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_op && !w_illegal) begin
                  bus.mem_addr  <= {i_alu_result_m[31:2], 2'b00};
                  bus.mem_we    <= i_mem_write_m;
                  bus.mem_be    <= w_be;
                  bus.mem_wdata <= w_wdata;
                  bus.mem_req   <= 1'b1;
                  r_funct3      <= i_funct3_m;
                  r_lane        <= i_alu_result_m[1:0];
                  r_state       <= S_BUSY;
               end else if (w_op) begin
                  r_read_data <= 32'd0;
               end
            end
            S_BUSY: begin
               if (bus.mem_ack) begin
                  bus.mem_req <= 1'b0;
                  if (!bus.mem_we) r_read_data <= w_load_val;
                  r_state <= S_DONE;
               end else if (w_cnt_next == TO_W'(TIMEOUT)) begin
                  bus.mem_req <= 1'b0;
                  r_read_data <= 32'd0;
                  r_bus_err   <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_cnt <= w_cnt_next;
               end
            end
            default: begin
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table of single accesses plus hand-written
// sequences for stray acks and reset during an outstanding request.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_m, mem_write_m;
   logic [2:0]  funct3_m;
   logic [31:0] alu_result_m, write_data_m;
   logic [31:0] read_data_m;
   logic        stall_m, misalign_m, bus_err_m;

   int checks   = 0;
   int failures = 0;

   mem_bus_if bus ();

   mem_access_unit #(.TIMEOUT(15), .TO_W(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_load_m       (load_m),
      .i_mem_write_m  (mem_write_m),
      .i_funct3_m     (funct3_m),
      .i_alu_result_m (alu_result_m),
      .i_write_data_m (write_data_m),
      .o_read_data_m  (read_data_m),
      .o_stall_m      (stall_m),
      .o_misalign_m   (misalign_m),
      .o_bus_err_m    (bus_err_m),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdata;
      int          dly;
      int          e_stall;
      int          e_req;
      int          e_mis;
      int          e_err;
      logic [31:0] e_rd;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      logic        e_we;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int stall_n = 0, req_n = 0, mis_n = 0, err_n = 0, cyc = 0;
      logic [31:0] cap_addr = '0, cap_wd = '0;
      logic [3:0]  cap_be = '0;
      logic        cap_we = 1'b0;
      bit          done = 0;
      @(posedge clk); #1;
      load_m = v.ld; mem_write_m = v.st; funct3_m = v.f3;
      alu_result_m = v.addr; write_data_m = v.wd;
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
      while (!done) begin
         @(negedge clk);
         cyc++;
         if (stall_m)    stall_n++;
         if (misalign_m) mis_n++;
         if (bus_err_m)  err_n++;
         bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
         if (bus.mem_req) begin
            req_n++;
            cap_addr = bus.mem_addr; cap_be = bus.mem_be;
            cap_wd = bus.mem_wdata;  cap_we = bus.mem_we;
            if (req_n == v.dly + 1) begin
               bus.mem_ack = 1'b1; bus.mem_rdata = v.rdata;
            end
         end
         if (!stall_m) done = 1;
         else if (cyc > 64) begin
            checks++; failures++;
            $display("FAIL v%0d_stuck actual=stall_after_%0d_cycles required=release", idx, cyc);
            done = 1;
         end
      end
      @(posedge clk); #1;
      load_m = 1'b0; mem_write_m = 1'b0; bus.mem_ack = 1'b0;
      check($sformatf("v%0d_stall_cycles", idx), stall_n, v.e_stall);
      check($sformatf("v%0d_req_cycles", idx), req_n, v.e_req);
      check($sformatf("v%0d_misalign", idx), mis_n, v.e_mis);
      check($sformatf("v%0d_bus_err", idx), err_n, v.e_err);
      check($sformatf("v%0d_read_data", idx), read_data_m, v.e_rd);
      if (v.e_req > 0) begin
         check($sformatf("v%0d_addr", idx), cap_addr, v.e_addr);
         check($sformatf("v%0d_be", idx), {28'd0, cap_be}, {28'd0, v.e_be});
         check($sformatf("v%0d_wdata", idx), cap_wd, v.e_wd);
         check($sformatf("v%0d_we", idx), {31'd0, cap_we}, {31'd0, v.e_we});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //          ld st  f3     addr          wd            rdata         dly st rq mi er e_rd          e_addr        be       e_wd          we
      vecs[0]  = '{1, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0,   2, 1, 0, 0, 32'hFFFF_FF80, 32'h0000_0100, 4'b1000, 32'h0,        1'b0};
      vecs[1]  = '{1, 0, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_1234, 3,   5, 4, 0, 0, 32'h0000_8001, 32'h0000_0100, 4'b1100, 32'h0,        1'b0};
      vecs[2]  = '{0, 1, 3'b000, 32'h0000_0201, 32'hDEAD_BEEF, 32'h1234_5678, 0,   2, 1, 0, 0, 32'h0000_8001, 32'h0000_0200, 4'b0010, 32'hEFEF_EFEF, 1'b1};
      vecs[3]  = '{1, 0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,         0,   0, 0, 1, 0, 32'h0,         32'h0,         4'b0000, 32'h0,        1'b0};
      vecs[4]  = '{1, 0, 3'b001, 32'h0000_0002, 32'h0,        32'hFFFE_1234, 1,   3, 2, 0, 0, 32'hFFFF_FFFE, 32'h0000_0000, 4'b1100, 32'h0,        1'b0};
      vecs[5]  = '{1, 0, 3'b010, 32'h0000_0010, 32'h0,        32'hCAFE_BABE, 0,   2, 1, 0, 0, 32'hCAFE_BABE, 32'h0000_0010, 4'b1111, 32'h0,        1'b0};
      vecs[6]  = '{0, 1, 3'b001, 32'h0000_0033, 32'h0000_5555, 32'h0,        0,   0, 0, 1, 0, 32'h0,         32'h0,         4'b0000, 32'h0,        1'b0};
      vecs[7]  = '{0, 1, 3'b010, 32'h0000_0044, 32'h0123_4567, 32'h0,        2,   4, 3, 0, 0, 32'h0,         32'h0000_0044, 4'b1111, 32'h0123_4567, 1'b1};
      vecs[8]  = '{1, 0, 3'b100, 32'h0000_0101, 32'h0,        32'h0000_9C00, 0,   2, 1, 0, 0, 32'h0000_009C, 32'h0000_0100, 4'b0010, 32'h0,        1'b0};
      vecs[9]  = '{1, 0, 3'b010, 32'h0000_0020, 32'h0,        32'h0,         255, 16, 15, 0, 1, 32'h0,       32'h0000_0020, 4'b1111, 32'h0,        1'b0};
      vecs[10] = '{1, 0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,         0,   0, 0, 1, 0, 32'h0,         32'h0,         4'b0000, 32'h0,        1'b0};
      vecs[11] = '{1, 1, 3'b010, 32'h0000_0008, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 0,   2, 1, 0, 0, 32'h0,         32'h0000_0008, 4'b1111, 32'hA5A5_A5A5, 1'b1};
      vecs[12] = '{0, 1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h0,        0,   2, 1, 0, 0, 32'h0,         32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 1'b1};
      vecs[13] = '{1, 0, 3'b000, 32'h0000_0100, 32'h0,        32'h0000_007F, 0,   2, 1, 0, 0, 32'h0000_007F, 32'h0000_0100, 4'b0001, 32'h0,        1'b0};

      rst_n = 1'b0;
      load_m = 1'b0; mem_write_m = 1'b0; funct3_m = 3'd0;
      alu_result_m = 32'd0; write_data_m = 32'd0;
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req",   {31'd0, bus.mem_req}, 32'd0);
      check("rst_we",    {31'd0, bus.mem_we}, 32'd0);
      check("rst_addr",  bus.mem_addr, 32'd0);
      check("rst_be",    {28'd0, bus.mem_be}, 32'd0);
      check("rst_wdata", bus.mem_wdata, 32'd0);
      check("rst_rd",    read_data_m, 32'd0);
      check("rst_stall", {31'd0, stall_m}, 32'd0);
      check("rst_flags", {30'd0, misalign_m, bus_err_m}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

      // Stray ack with no request outstanding must be ignored.
      @(posedge clk); #1;
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
      repeat (3) begin
         @(negedge clk);
         check("idle_ack_req",   {31'd0, bus.mem_req}, 32'd0);
         check("idle_ack_stall", {31'd0, stall_m}, 32'd0);
      end
      check("idle_ack_rd", read_data_m, 32'h0000_007F);
      @(posedge clk); #1;
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;

      // Reset arriving together with mem_ack during BUSY abandons the access.
      load_m = 1'b1; funct3_m = 3'b010; alu_result_m = 32'h0000_0040;
      @(posedge clk); #1;
      check("rstbusy_req_up", {31'd0, bus.mem_req}, 32'd1);
      @(negedge clk);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_1111;
      rst_n = 1'b0; load_m = 1'b0;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
      check("rstbusy_req",   {31'd0, bus.mem_req}, 32'd0);
      check("rstbusy_rd",    read_data_m, 32'd0);
      check("rstbusy_stall", {31'd0, stall_m}, 32'd0);
      check("rstbusy_err",   {31'd0, bus_err_m}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_vec(vecs[5], 14);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
